audio_dac_feeder: RTL and testbench
===================================

Name: audio_dac_feeder

Overview:
Elastic sample buffer directly upstream of the WM8978 controller's playback path; drives its dac_data input and consumes its tx_done strobe.
- User logic pushes audio words through a valid/ready interface.
- The block prefills a FIFO, then presents one new word on dac_data per tx_done.
- On underrun it substitutes silence and re-prefills, so the codec never replays stale or garbage words.

Parameters:
WL, 32, audio word length in bits (matches the controller's word length)
DEPTH_LOG2, 6, log2 of FIFO depth (64 words)
PREFILL, 16, words required in FIFO before playback starts/resumes (1..2**DEPTH_LOG2)

Ports:
clk  input  1  block clock; tx_done and all inputs synchronous to it
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
enable  input  1  1 = run; 0 = flush FIFO, output silence
s_data  input  WL  sample word from producer
s_valid  input  1  s_data valid
s_ready  output  1  FIFO can accept a word this cycle
tx_done  input  1  single-cycle pulse: codec finished sending current dac_data
dac_data  output  WL  word for the controller's dac_data input
level  output  DEPTH_LOG2+1  current FIFO occupancy
playing  output  1  1 while in PLAY state
underrun_cnt  output  16  saturating count of underrun events

Behaviour:
- Reset (rst_n=0 at clk edge):
  - FIFO emptied; level=0; state=FILL.
  - dac_data=0, playing=0, underrun_cnt=0.
  - s_ready=0 during reset; s_ready=1 from the first cycle after release.
- Clock domain: tx_done arrives already synchronised to clk as one-cycle pulses (crossing from aud_bclk is done outside this block). Back-to-back tx_done is legal and each pulse is honoured.
- Write:
  - push when s_valid && s_ready.
  - s_ready = enable && (level != 2**DEPTH_LOG2), derived from registered level.
  - A word offered while full is not accepted, and the producer holds it.
- States:
  - FILL: dac_data=0, playing=0, tx_done ignored (no pop). When level >= PREFILL, go to PLAY next cycle.
  - PLAY, on tx_done with level>0: pop the head word; dac_data = head, registered one cycle after the tx_done cycle; level decrements.
  - PLAY, on tx_done with level==0: underrun. dac_data=0 next cycle, underrun_cnt += 1 (saturates at 16'hFFFF), state goes to FILL.
  - PLAY, no tx_done: dac_data holds.
- Simultaneous push and pop in the same cycle: both occur and level is unchanged. A push into a FIFO that is empty that cycle is not visible to a same-cycle pop, so that pop is an underrun.
- enable=0:
  - Next cycle: FIFO flushed, level=0, state=FILL, dac_data=0.
  - s_ready=0 while enable=0.
  - underrun_cnt is retained.
  - Re-enabling starts from FILL.
- Latency:
  - First accepted word reaches dac_data at the first tx_done after PREFILL words are buffered, plus 1 cycle.
  - tx_done to dac_data update: 1 cycle.
- Pointers: DEPTH_LOG2-bit read/write pointers wrap modulo depth; level is a separate (DEPTH_LOG2+1)-bit counter.
- Data path: data passes unmodified and is MSB-aligned, WL bits, no scaling.
- Reset mid-operation: reset wins over all other events in that cycle.

Decomposition:
- Shared package audio_pkg:
  - WL default constant.
  - State enumeration (FILL, PLAY).
  - Silence constant (all-zero word).
- One natural sub-module, audio_sample_fifo: synchronous single-clock FIFO with push/pop/level/full/empty, parameterised by WL and DEPTH_LOG2, same clk/rst_n.
- The feeder FSM, dac_data register and underrun counter live in the top.

Test Plan:
- Reset then enable=1, push 15 words 0x1..0xF, pulse tx_done 3 times -> playing=0, dac_data=0, level=15, underrun_cnt=0.
- Push 16th word 0x10 -> PLAY after the next cycle; first tx_done gives dac_data=0x1 one cycle later and level=15; next tx_done gives 0x2.
- Prefill 16 words, issue 17 tx_done pulses with no further pushes -> words 0x1..0x10 in order, then dac_data=0, underrun_cnt=1, state FILL.
- Push 64 words with no pops -> s_ready=0 at level=64; 65th word held by producer. After one tx_done in PLAY, s_ready=1 the following cycle.
- Same-cycle push and tx_done at level=20 -> level stays 20 and popped word is correct. enable=0 for 1 cycle -> level=0, dac_data=0, FILL.
- Drive underrun 65537 times (force counter near max) -> underrun_cnt saturates at 0xFFFF. Assert rst_n=0 mid-PLAY -> all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared types and constants for the audio DAC feeder path.
package audio_pkg;

  // Default audio word length, matching the codec controller.
  localparam int unsigned DefaultWl = 32;

  // Feeder playback state.
  typedef enum logic {
    StFill = 1'b0,
    StPlay = 1'b1
  } feed_state_e;

  // Word presented to the codec when nothing valid is available.
  localparam logic [DefaultWl-1:0] Silence = '0;

endpackage

// File: rtl/audio_sample_fifo.sv
// Single-clock sample FIFO with explicit occupancy counter and synchronous flush.
module audio_sample_fifo #(
  parameter int unsigned WL         = 32,
  parameter int unsigned DEPTH_LOG2 = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic [WL-1:0]         data_i,
  input  logic                  pop_i,
  output logic [WL-1:0]         data_o,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DepthLvl = (DEPTH_LOG2 + 1)'(Depth);

  logic [WL-1:0]         mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  do_push, do_pop;

  assign full_o  = (level_q == DepthLvl);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign data_o  = mem_q[rd_ptr_q];

  // Overflowing pushes and underflowing pops are dropped here as a safety net.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Next-state for pointers and occupancy; pointers wrap modulo depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Pointer and occupancy registers; reset and flush both empty the FIFO.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Sample storage; contents need no reset since occupancy guards reads.
  always_ff @(posedge clk_i) begin
    if (rst_ni && !flush_i && do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/audio_dac_feeder.sv
// Elastic buffer feeding the codec controller's dac_data, one word per tx_done.
module audio_dac_feeder
  import audio_pkg::*;
#(
  parameter int unsigned WL         = DefaultWl,
  parameter int unsigned DEPTH_LOG2 = 6,
  parameter int unsigned PREFILL    = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                enable_i,
  input  logic [WL-1:0]       s_data_i,
  input  logic                s_valid_i,
  output logic                s_ready_o,
  input  logic                tx_done_i,
  output logic [WL-1:0]       dac_data_o,
  output logic [DEPTH_LOG2:0] level_o,
  output logic                playing_o,
  output logic [15:0]         underrun_cnt_o
);

  localparam logic [DEPTH_LOG2:0] PrefillLvl = (DEPTH_LOG2 + 1)'(PREFILL);

  feed_state_e   state_q, state_d;
  logic [WL-1:0] dac_data_q, dac_data_d;
  logic [15:0]   underrun_cnt_q, underrun_cnt_d;

  logic          fifo_full, fifo_empty, push, pop;
  logic [WL-1:0] fifo_head;
  logic [DEPTH_LOG2:0] fifo_level;

  // Ready comes from registered occupancy only; held low while in reset.
  assign s_ready_o = rst_ni & enable_i & ~fifo_full;
  assign push      = s_valid_i & s_ready_o;

  audio_sample_fifo #(
    .WL         (WL),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (~enable_i),
    .push_i  (push),
    .data_i  (s_data_i),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Feeder FSM: prefill, then one pop per tx_done; an empty FIFO at tx_done is an underrun.
  always_comb begin
    state_d        = state_q;
    dac_data_d     = dac_data_q;
    underrun_cnt_d = underrun_cnt_q;
    pop            = 1'b0;
    if (!enable_i) begin
      state_d    = StFill;
      dac_data_d = WL'(Silence);
    end else begin
      unique case (state_q)
        StFill: begin
          dac_data_d = WL'(Silence);
          if (fifo_level >= PrefillLvl) state_d = StPlay;
        end
        StPlay: begin
          if (tx_done_i) begin
            if (!fifo_empty) begin
              pop        = 1'b1;
              dac_data_d = fifo_head;
            end else begin
              dac_data_d = WL'(Silence);
              state_d    = StFill;
              if (underrun_cnt_q != 16'hFFFF) underrun_cnt_d = underrun_cnt_q + 16'd1;
            end
          end
        end
        default: state_d = StFill;
      endcase
    end
  end

  // State, output word and underrun counter registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q        <= StFill;
      dac_data_q     <= '0;
      underrun_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      dac_data_q     <= dac_data_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  assign dac_data_o     = dac_data_q;
  assign level_o        = fifo_level;
  assign playing_o      = (state_q == StPlay);
  assign underrun_cnt_o = underrun_cnt_q;

endmodule

// File: tb/tb_audio_dac_feeder.sv
// Directed self-checking bench for audio_dac_feeder (WL=32, depth 64, prefill 16).
module tb_audio_dac_feeder;

  logic        clk = 1'b0;
  logic        rst_n, enable, s_valid, s_ready, tx_done, playing;
  logic [31:0] s_data, dac_data;
  logic [6:0]  level;
  logic [15:0] underrun_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  audio_dac_feeder #(
    .WL         (32),
    .DEPTH_LOG2 (6),
    .PREFILL    (16)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .enable_i       (enable),
    .s_data_i       (s_data),
    .s_valid_i      (s_valid),
    .s_ready_o      (s_ready),
    .tx_done_i      (tx_done),
    .dac_data_o     (dac_data),
    .level_o        (level),
    .playing_o      (playing),
    .underrun_cnt_o (underrun_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; registered outputs are settled afterwards.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] d);
    s_valid = 1'b1;
    s_data  = d;
    step();
    s_valid = 1'b0;
  endtask

  task automatic pulse_tx();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
  endtask

  // Prefill, drain all words, then one more tx_done to cause an underrun.
  task automatic do_underrun();
    for (int i = 0; i < 16; i++) push_word(32'h500 + i);
    step();
    for (int i = 0; i < 17; i++) pulse_tx();
  endtask

  initial begin
    rst_n   = 1'b0;
    enable  = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    tx_done = 1'b0;
    step();
    step();
    check_eq("rst_s_ready", {31'd0, s_ready}, 32'd0);
    check_eq("rst_level", {25'd0, level}, 32'd0);
    check_eq("rst_dac", dac_data, 32'd0);
    check_eq("rst_playing", {31'd0, playing}, 32'd0);
    check_eq("rst_underrun", {16'd0, underrun_cnt}, 32'd0);
    rst_n = 1'b1;
    #1;
    check_eq("post_rst_ready", {31'd0, s_ready}, 32'd1);

    // 15 words is below prefill; tx_done is ignored in FILL.
    for (int i = 1; i <= 15; i++) push_word(i);
    for (int i = 0; i < 3; i++) pulse_tx();
    check_eq("fill_playing", {31'd0, playing}, 32'd0);
    check_eq("fill_dac", dac_data, 32'd0);
    check_eq("fill_level", {25'd0, level}, 32'd15);
    check_eq("fill_underrun", {16'd0, underrun_cnt}, 32'd0);

    // 16th word reaches prefill; PLAY follows one cycle later.
    push_word(32'h10);
    check_eq("prefill_not_yet", {31'd0, playing}, 32'd0);
    step();
    check_eq("play_entered", {31'd0, playing}, 32'd1);
    pulse_tx();
    check_eq("first_word", dac_data, 32'h1);
    check_eq("first_level", {25'd0, level}, 32'd15);
    pulse_tx();
    check_eq("second_word", dac_data, 32'h2);
    step();
    check_eq("dac_hold", dac_data, 32'h2);

    // Drain the rest in order, then underrun.
    for (int i = 3; i <= 16; i++) begin
      pulse_tx();
      check_eq("drain_word", dac_data, i);
    end
    pulse_tx();
    check_eq("underrun_dac", dac_data, 32'd0);
    check_eq("underrun_cnt1", {16'd0, underrun_cnt}, 32'd1);
    check_eq("underrun_fill", {31'd0, playing}, 32'd0);

    // Fill to capacity with no pops.
    for (int i = 0; i < 64; i++) push_word(32'h100 + i);
    check_eq("full_level", {25'd0, level}, 32'd64);
    check_eq("full_ready", {31'd0, s_ready}, 32'd0);
    s_valid = 1'b1;
    s_data  = 32'hDEAD;
    step();
    check_eq("full_held", {25'd0, level}, 32'd64);
    pulse_tx();
    check_eq("full_pop_word", dac_data, 32'h100);
    check_eq("full_pop_level", {25'd0, level}, 32'd63);
    check_eq("ready_after_pop", {31'd0, s_ready}, 32'd1);
    step();
    s_valid = 1'b0;
    check_eq("held_accepted", {25'd0, level}, 32'd64);

    // enable low for one cycle flushes everything but the counter.
    enable = 1'b0;
    #1;
    check_eq("disable_ready", {31'd0, s_ready}, 32'd0);
    step();
    enable = 1'b1;
    check_eq("flush_level", {25'd0, level}, 32'd0);
    check_eq("flush_dac", dac_data, 32'd0);
    check_eq("flush_playing", {31'd0, playing}, 32'd0);
    check_eq("flush_keep_cnt", {16'd0, underrun_cnt}, 32'd1);

    // Same-cycle push and pop at level 20.
    for (int i = 0; i < 20; i++) push_word(32'h200 + i);
    check_eq("lvl20_playing", {31'd0, playing}, 32'd1);
    check_eq("lvl20_level", {25'd0, level}, 32'd20);
    s_valid = 1'b1;
    s_data  = 32'h300;
    tx_done = 1'b1;
    step();
    s_valid = 1'b0;
    tx_done = 1'b0;
    check_eq("pushpop_level", {25'd0, level}, 32'd20);
    check_eq("pushpop_word", dac_data, 32'h200);
    for (int i = 1; i < 20; i++) pulse_tx();
    check_eq("pushpop_last_old", dac_data, 32'h213);
    pulse_tx();
    check_eq("pushpop_new_word", dac_data, 32'h300);
    check_eq("pushpop_empty", {25'd0, level}, 32'd0);

    // Push into an empty FIFO alongside tx_done is still an underrun.
    s_valid = 1'b1;
    s_data  = 32'h400;
    tx_done = 1'b1;
    step();
    s_valid = 1'b0;
    tx_done = 1'b0;
    check_eq("empty_pp_dac", dac_data, 32'd0);
    check_eq("empty_pp_cnt", {16'd0, underrun_cnt}, 32'd2);
    check_eq("empty_pp_fill", {31'd0, playing}, 32'd0);
    check_eq("empty_pp_level", {25'd0, level}, 32'd1);

    // Counter saturation: preload near the top, then underrun twice.
    enable = 1'b0;
    step();
    enable = 1'b1;
    force dut.underrun_cnt_q = 16'hFFFE;
    step();
    release dut.underrun_cnt_q;
    do_underrun();
    check_eq("sat_reach", {16'd0, underrun_cnt}, 32'hFFFF);
    do_underrun();
    check_eq("sat_hold", {16'd0, underrun_cnt}, 32'hFFFF);

    // Reset in the middle of playback.
    for (int i = 0; i < 16; i++) push_word(32'h600 + i);
    step();
    pulse_tx();
    check_eq("midplay_word", dac_data, 32'h600);
    check_eq("midplay_playing", {31'd0, playing}, 32'd1);
    rst_n = 1'b0;
    step();
    check_eq("midrst_level", {25'd0, level}, 32'd0);
    check_eq("midrst_dac", dac_data, 32'd0);
    check_eq("midrst_playing", {31'd0, playing}, 32'd0);
    check_eq("midrst_cnt", {16'd0, underrun_cnt}, 32'd0);
    check_eq("midrst_ready", {31'd0, s_ready}, 32'd0);
    rst_n = 1'b1;
    step();
    check_eq("midrst_release", {31'd0, s_ready}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
